// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// state codes, opcode/funct values, ALU operation classes and mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_REX    = 4'd6,
    ST_RWB    = 4'd7,
    ST_IEX    = 4'd8,
    ST_IWB    = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11,
    ST_JAL    = 4'd12,
    ST_JR     = 4'd13
  } stateT;

  typedef enum logic [3:0] {
    CL_ILLEGAL = 4'd0,
    CL_LW      = 4'd1,
    CL_SW      = 4'd2,
    CL_RTYPE   = 4'd3,
    CL_JR      = 4'd4,
    CL_ADDI    = 4'd5,
    CL_ORI     = 4'd6,
    CL_ANDI    = 4'd7,
    CL_LUI     = 4'd8,
    CL_BEQ     = 4'd9,
    CL_BNE     = 4'd10,
    CL_J       = 4'd11,
    CL_JAL     = 4'd12
  } instrClassT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCondEQ;
    logic       pcWriteCondNE;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic       aluSrcA;
    logic       zeroExt;
    logic       illegal;
    logic [1:0] regDst;
    logic [1:0] memtoReg;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic [2:0] aluOp;
  } ctrlT;

  // ALU class for the immediate-arithmetic group; ADD covers ADDI.
  function automatic logic [2:0] immAluOp(input instrClassT cls);
    logic [2:0] op;
    case (cls)
      CL_ORI:  op = ALU_OR;
      CL_ANDI: op = ALU_AND;
      CL_LUI:  op = ALU_LUI;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic immZeroExt(input instrClassT cls);
    return (cls == CL_ORI) || (cls == CL_ANDI);
  endfunction

endpackage

// File: rtl/ctrl_opclass.sv
// Combinational opcode/funct classifier. JAL and JR fold into the illegal
// class when they are not enabled.
module ctrl_opclass
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned EN_JALJR = 1
) (
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  output instrClassT instrClass,
  output logic       legal
);

  instrClassT rawClass;

  always_comb begin
    rawClass = CL_ILLEGAL;
    case (OP)
      OP_RTYPE: rawClass = (Funct == FUNCT_JR) ? CL_JR : CL_RTYPE;
      OP_LW:    rawClass = CL_LW;
      OP_SW:    rawClass = CL_SW;
      OP_ADDI:  rawClass = CL_ADDI;
      OP_ORI:   rawClass = CL_ORI;
      OP_ANDI:  rawClass = CL_ANDI;
      OP_LUI:   rawClass = CL_LUI;
      OP_BEQ:   rawClass = CL_BEQ;
      OP_BNE:   rawClass = CL_BNE;
      OP_J:     rawClass = CL_J;
      OP_JAL:   rawClass = CL_JAL;
      default:  rawClass = CL_ILLEGAL;
    endcase
  end

  always_comb begin
    instrClass = rawClass;
    if ((EN_JALJR == 0) && ((rawClass == CL_JAL) || (rawClass == CL_JR))) begin
      instrClass = CL_ILLEGAL;
    end
  end

  assign legal = (instrClass != CL_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM. Outputs are a Moore decode of the state
// register; memory-side strobes are qualified by MemReady when MEM_WAIT=1.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned EN_JALJR = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCondEQ,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       ZeroExt,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [3:0] State,
  output logic       Illegal
);

  stateT      stateReg;
  instrClassT classReg;
  instrClassT opClass;
  logic       opLegal;
  logic       memOk;
  ctrlT       ctrl;

  ctrl_opclass #(
    .EN_JALJR(EN_JALJR)
  ) uOpclass (
    .OP        (OP),
    .Funct     (Funct),
    .instrClass(opClass),
    .legal     (opLegal)
  );

  assign memOk = (MEM_WAIT == 0) || MemReady;

  // Instruction class is captured in DECODE so later states do not depend
  // on OP staying stable beyond the decode cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= ST_FETCH;
      classReg <= CL_ILLEGAL;
    end else begin
      case (stateReg)
        ST_FETCH: begin
          if (memOk) stateReg <= ST_DECODE;
        end
        ST_DECODE: begin
          classReg <= opClass;
          case (opClass)
            CL_LW, CL_SW:                      stateReg <= ST_MEMADR;
            CL_RTYPE:                          stateReg <= ST_REX;
            CL_JR:                             stateReg <= ST_JR;
            CL_ADDI, CL_ORI, CL_ANDI, CL_LUI:  stateReg <= ST_IEX;
            CL_BEQ, CL_BNE:                    stateReg <= ST_BRANCH;
            CL_J:                              stateReg <= ST_JUMP;
            CL_JAL:                            stateReg <= ST_JAL;
            default:                           stateReg <= ST_FETCH;
          endcase
        end
        ST_MEMADR: stateReg <= (classReg == CL_SW) ? ST_MEMWR : ST_MEMRD;
        ST_MEMRD: begin
          if (memOk) stateReg <= ST_MEMWB;
        end
        ST_MEMWR: begin
          if (memOk) stateReg <= ST_FETCH;
        end
        ST_REX:  stateReg <= ST_RWB;
        ST_IEX:  stateReg <= ST_IWB;
        default: stateReg <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    case (stateReg)
      ST_FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALU_ADD;
        ctrl.pcSrc   = PCSRC_ALU;
        ctrl.irWrite = memOk;
        ctrl.pcWrite = memOk;
      end
      ST_DECODE: begin
        ctrl.aluSrcB = SRCB_IMMSH;
        ctrl.aluOp   = ALU_ADD;
        ctrl.illegal = !opLegal;
      end
      ST_MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      ST_MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = REGDST_RT;
        ctrl.memtoReg = WB_MEM;
      end
      ST_MEMWR: begin
        ctrl.memWrite = memOk;
        ctrl.iorD     = 1'b1;
      end
      ST_REX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_REG;
        ctrl.aluOp   = ALU_FUNCT;
      end
      ST_RWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = REGDST_RD;
        ctrl.memtoReg = WB_ALU;
      end
      ST_IEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = immAluOp(classReg);
        ctrl.zeroExt = immZeroExt(classReg);
      end
      ST_IWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = REGDST_RT;
        ctrl.memtoReg = WB_ALU;
      end
      ST_BRANCH: begin
        ctrl.aluSrcA       = 1'b1;
        ctrl.aluSrcB       = SRCB_REG;
        ctrl.aluOp         = ALU_SUB;
        ctrl.pcSrc         = PCSRC_ALUOUT;
        ctrl.pcWriteCondEQ = (classReg == CL_BEQ);
        ctrl.pcWriteCondNE = (classReg == CL_BNE);
      end
      ST_JUMP: begin
        ctrl.pcWrite = 1'b1;
        ctrl.pcSrc   = PCSRC_JUMP;
      end
      ST_JAL: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSrc    = PCSRC_JUMP;
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = REGDST_RA;
        ctrl.memtoReg = WB_PC;
      end
      ST_JR: begin
        ctrl.pcWrite = 1'b1;
        ctrl.pcSrc   = PCSRC_REG;
      end
      default: ;
    endcase
    // Nothing may strobe while reset is held, even before the flop settles.
    if (reset) ctrl = '0;
  end

  assign PCWrite       = ctrl.pcWrite;
  assign PCWriteCondEQ = ctrl.pcWriteCondEQ;
  assign PCWriteCondNE = ctrl.pcWriteCondNE;
  assign IorD          = ctrl.iorD;
  assign MemRead       = ctrl.memRead;
  assign MemWrite      = ctrl.memWrite;
  assign IRWrite       = ctrl.irWrite;
  assign RegWrite      = ctrl.regWrite;
  assign ALUSrcA       = ctrl.aluSrcA;
  assign ZeroExt       = ctrl.zeroExt;
  assign Illegal       = ctrl.illegal;
  assign RegDst        = ctrl.regDst;
  assign MemtoReg      = ctrl.memtoReg;
  assign ALUSrcB       = ctrl.aluSrcB;
  assign PCSrc         = ctrl.pcSrc;
  assign ALUOp         = ctrl.aluOp;
  assign State         = stateReg;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameter MEM_WAIT, default 0, meaning: 1 = memory states stall until MemReady; 0 = MemReady ignored.
REQ-003 Parameter EN_JALJR, default 1, meaning: 1 = JAL/JR supported; 0 = JAL/JR treated as illegal.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 OP  input  6  opcode from instruction register.
REQ-007 Funct  input  6  function field from instruction register.
REQ-008 MemReady  input  1  memory access complete this cycle.
REQ-009 PCWrite, PCWriteCondEQ, PCWriteCondNE  output  1 each  unconditional, BEQ and BNE PC write enables.
REQ-010 IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ZeroExt  output  1 each  datapath controls.
REQ-011 RegDst, MemtoReg, ALUSrcB, PCSrc  output  2 each  mux selects.
REQ-012 ALUOp  output  3  ALU operation class.
REQ-013 State  output  4  current state code, debug.
REQ-014 Illegal  output  1  unsupported opcode/funct detected.

Function
REQ-015 Outputs SHALL be a Moore decode of State, except IRWrite, PCWrite and MDR-related advance, which SHALL be gated by MemReady when MEM_WAIT=1.
REQ-016 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BRANCH, JUMP, JAL, JR.
REQ-017 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSrc=00, IRWrite=PCWrite=1 → DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100 (branch target).
REQ-018a DECODE next state: LW/SW→MEMADR; R-type→REX, except Funct=0x08→JR; ADDI/ORI/ANDI/LUI→IEX; BEQ/BNE→BRANCH; J→JUMP; JAL→JAL.
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=100 → MEMRD (LW) or MEMWR (SW).
REQ-020 MEMRD: MemRead=1, IorD=1 → MEMWB. MEMWB: RegWrite=1, RegDst=00, MemtoReg=01 → FETCH.
REQ-021 MEMWR: MemWrite=1, IorD=1 → FETCH.
REQ-022 REX: ALUSrcA=1, ALUSrcB=00, ALUOp=111 → RWB. RWB: RegWrite=1, RegDst=01, MemtoReg=00 → FETCH.
REQ-023 IEX: ALUSrcA=1, ALUSrcB=10; ALUOp is ADDI=100, ORI=101, ANDI=010, LUI=110; ZeroExt=1 for ORI/ANDI → IWB.
REQ-023a IWB: RegWrite=1, RegDst=00, MemtoReg=00 → FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSrc=01; PCWriteCondEQ=1 for BEQ and PCWriteCondNE=1 for BNE → FETCH.
REQ-025 JUMP: PCWrite=1, PCSrc=10 → FETCH.
REQ-025a JAL: PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, MemtoReg=10 → FETCH.
REQ-025b JR: PCWrite=1, PCSrc=11 → FETCH.
REQ-026 Latency with MEM_WAIT=0: LW 5 cycles; R-type/ADDI-class/SW 4 cycles; BEQ/BNE/J/JAL/JR 3 cycles.
REQ-027 With MEM_WAIT=1, FETCH/MEMRD/MEMWR SHALL hold while MemReady=0; write/advance strobes SHALL assert only in the MemReady=1 cycle.
REQ-028 An unsupported OP, or JAL/JR with EN_JALJR=0, SHALL assert Illegal during DECODE for exactly 1 cycle, return to FETCH, and assert no write enables.
REQ-029 All unlisted outputs in any state SHALL be 0.

Reset
REQ-030 While reset=1, State SHALL be FETCH and all outputs SHALL be forced to 0 combinationally.
REQ-031 The first fetch SHALL occur in the first cycle after reset deasserts; reset mid-instruction SHALL abort with no further write strobe.

Structure
REQ-032 Package mips_ctrl_pkg SHALL hold the state enum, opcode/funct constants, ALUOp codes, and mux select codes.
REQ-033 Sub-module ctrl_opclass SHALL classify OP/Funct into an instruction class and legality flag (combinational).

Verification
REQ-034 R-type OP=0x00, Funct=0x20, MEM_WAIT=0 → states FETCH, DECODE, REX, RWB; RegWrite=1 with RegDst=01 only in RWB.
REQ-035 LW OP=0x23, MEM_WAIT=1, MemReady low 2 cycles in MEMRD → MEMRD held 3 cycles; RegWrite in MEMWB; total 7 cycles.
REQ-036 BNE OP=0x05 → PCWriteCondNE=1, PCWriteCondEQ=0, PCSrc=01 in cycle 3.
REQ-037 JAL OP=0x03 → RegDst=10, MemtoReg=10, PCWrite=1, PCSrc=10 in cycle 3; with EN_JALJR=0 → Illegal=1 in DECODE, then FETCH.
REQ-038 OP=0x3F → Illegal pulses 1 cycle, no write enables asserted, next state FETCH.
REQ-039 Reset asserted in MEMADR of SW → MemWrite never asserts; State=FETCH immediately.
